// File: rtl/vga2_pkg.sv
// Shared palette-loader types and constants: FSM state encoding, bank/entry widths,
// and the {bank, index} to aux byte-address helper.
package vga2_pkg;
    localparam int BANK_W     = 2;
    localparam int ENTRY_W    = 8;
    localparam int PAL_ADDR_W = BANK_W + ENTRY_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    function automatic logic [PAL_ADDR_W-1:0] pal_byte_addr(
        input logic [BANK_W-1:0]  bank,
        input logic [ENTRY_W-1:0] index
    );
        return {bank, index, 2'b00};
    endfunction
endpackage

// File: rtl/vga2_aux_arb.sv
// Combinational 2:1 fixed-priority mux onto the palette aux port, zero latency.
// The CPU always wins; ld_grant tells the loader its write went out this cycle.
module vga2_aux_arb
    import vga2_pkg::*;
(
    input  logic                  cpu_request,
    input  logic [PAL_ADDR_W-1:0] cpu_address,
    input  logic                  cpu_write,
    input  logic [31:0]           cpu_wdata,
    input  logic                  ld_request,
    input  logic [PAL_ADDR_W-1:0] ld_address,
    input  logic [31:0]           ld_wdata,
    output logic                  aux_request,
    output logic [PAL_ADDR_W-1:0] aux_address,
    output logic                  aux_write,
    output logic [31:0]           aux_wdata,
    output logic                  ld_grant
);
    always_comb begin
        aux_request = cpu_request;
        aux_address = cpu_address;
        aux_write   = cpu_write;
        aux_wdata   = cpu_wdata;
        ld_grant    = 1'b0;
        // Loader only drives the port when the CPU is silent; otherwise it is a pass-through.
        if (!cpu_request && ld_request) begin
            aux_request = 1'b1;
            aux_address = ld_address;
            aux_write   = 1'b1;
            aux_wdata   = ld_wdata;
            ld_grant    = 1'b1;
        end
    end
endmodule

// File: rtl/vga2_palette_loader.sv
// Bulk palette loader sharing the aux port with the CPU; first write 1 cycle after start,
// 1 entry/cycle sustained, stream stalled (stream_ready=0) whenever the CPU requests.
module vga2_palette_loader
    import vga2_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_request,
    input  logic [PAL_ADDR_W-1:0] cpu_address,
    input  logic                  cpu_write,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    input  logic                  load_start,
    input  logic [BANK_W-1:0]     load_bank,
    input  logic [ENTRY_W-1:0]    load_base,
    input  logic [ENTRY_W:0]      load_count,
    input  logic                  load_abort,
    input  logic                  stream_valid,
    input  logic [23:0]           stream_data,
    output logic                  stream_ready,
    output logic                  aux_palette_request,
    output logic [PAL_ADDR_W-1:0] aux_palette_address,
    output logic                  aux_palette_write,
    output logic [31:0]           aux_palette_wdata,
    input  logic [31:0]           aux_palette_rdata,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ENTRY_W:0]      load_written
);
    state_e               state_q, state_d;
    logic [BANK_W-1:0]    bank_q, bank_d;
    logic [ENTRY_W-1:0]   index_q, index_d;
    logic [ENTRY_W:0]     remaining_q, remaining_d;
    logic [ENTRY_W:0]     written_q, written_d;
    logic                 in_load;
    logic                 ld_hs;

    assign in_load      = (state_q == LOAD);
    assign stream_ready = in_load && !cpu_request;
    assign load_busy    = in_load;
    assign load_done    = (state_q == DONE);
    assign load_written = written_q;
    // The loader never reads, so any returned data belongs to the CPU.
    assign cpu_rdata    = aux_palette_rdata;

    vga2_aux_arb u_arb (
        .cpu_request (cpu_request),
        .cpu_address (cpu_address),
        .cpu_write   (cpu_write),
        .cpu_wdata   (cpu_wdata),
        .ld_request  (in_load && stream_valid),
        .ld_address  (pal_byte_addr(bank_q, index_q)),
        .ld_wdata    ({8'h00, stream_data}),
        .aux_request (aux_palette_request),
        .aux_address (aux_palette_address),
        .aux_write   (aux_palette_write),
        .aux_wdata   (aux_palette_wdata),
        .ld_grant    (ld_hs)
    );

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        written_d   = written_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    bank_d      = load_bank;
                    index_d     = load_base;
                    remaining_d = load_count;
                    written_d   = '0;
                    state_d     = (load_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (ld_hs) begin
                    // Index wraps within the bank; the bank never changes mid-load.
                    index_d     = index_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    written_d   = written_q + 1'b1;
                    if (remaining_q == (ENTRY_W+1)'(1)) begin
                        state_d = DONE;
                    end
                end
                if (load_abort) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            index_q     <= '0;
            remaining_q <= '0;
            written_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            written_q   <= written_d;
        end
    end
endmodule

// File: tb/tb_vga2_palette_loader.sv
// Bench for vga2_palette_loader: palette RAM model, CPU pass-through vector table,
// directed load sequences and randomized loads checked against an expected write list.
module tb_vga2_palette_loader;
    logic        clock;
    logic        reset;
    logic        cpu_request;
    logic [11:0] cpu_address;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        load_start;
    logic [1:0]  load_bank;
    logic [7:0]  load_base;
    logic [8:0]  load_count;
    logic        load_abort;
    logic        stream_valid;
    logic [23:0] stream_data;
    logic        stream_ready;
    logic        aux_palette_request;
    logic [11:0] aux_palette_address;
    logic        aux_palette_write;
    logic [31:0] aux_palette_wdata;
    logic [31:0] aux_palette_rdata;
    logic        load_busy;
    logic        load_done;
    logic [8:0]  load_written;

    vga2_palette_loader dut (
        .clock               (clock),
        .reset               (reset),
        .cpu_request         (cpu_request),
        .cpu_address         (cpu_address),
        .cpu_write           (cpu_write),
        .cpu_wdata           (cpu_wdata),
        .cpu_rdata           (cpu_rdata),
        .load_start          (load_start),
        .load_bank           (load_bank),
        .load_base           (load_base),
        .load_count          (load_count),
        .load_abort          (load_abort),
        .stream_valid        (stream_valid),
        .stream_data         (stream_data),
        .stream_ready        (stream_ready),
        .aux_palette_request (aux_palette_request),
        .aux_palette_address (aux_palette_address),
        .aux_palette_write   (aux_palette_write),
        .aux_palette_wdata   (aux_palette_wdata),
        .aux_palette_rdata   (aux_palette_rdata),
        .load_busy           (load_busy),
        .load_done           (load_done),
        .load_written        (load_written)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Palette RAM: one-cycle read latency, returns 0 when no read was issued.
    logic [31:0] pal_env [1024];
    always @(posedge clock) begin
        aux_palette_rdata <= 32'h0;
        if (aux_palette_request) begin
            if (aux_palette_write) pal_env[aux_palette_address[11:2]] <= aux_palette_wdata;
            else                   aux_palette_rdata <= pal_env[aux_palette_address[11:2]];
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [43:0] obs_q [$];
    bit          rd_pend = 0;
    logic [31:0] rd_exp;
    bit          hs;
    bit          done_seen;
    int          done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at the falling edge: checks the arbitration rules and records loader writes.
    task automatic observe();
        if (rd_pend) chk("cpu_rdata", cpu_rdata, rd_exp);
        else         chk("cpu_rdata_zero", cpu_rdata, 32'h0);
        rd_pend = 0;
        chk("ready_rule", {31'h0, stream_ready}, {31'h0, load_busy && !cpu_request});
        if (cpu_request) begin
            chk("arb_req", {31'h0, aux_palette_request}, 32'h1);
            chk("arb_addr", {20'h0, aux_palette_address}, {20'h0, cpu_address});
            chk("arb_wr", {31'h0, aux_palette_write}, {31'h0, cpu_write});
            chk("arb_wdata", aux_palette_wdata, cpu_wdata);
            if (!cpu_write) begin
                rd_pend = 1;
                rd_exp  = pal_env[cpu_address[11:2]];
            end
        end else if (aux_palette_request) begin
            chk("ld_is_write", {31'h0, aux_palette_write}, 32'h1);
            obs_q.push_back({aux_palette_address, aux_palette_wdata});
        end
        hs = stream_valid && stream_ready;
        if (hs) chk("ld_wdata", aux_palette_wdata, {8'h00, stream_data});
        done_seen = load_done;
        if (load_done) done_cnt++;
    endtask

    task automatic idle_inputs();
        cpu_request  = 0;
        cpu_write    = 0;
        load_start   = 0;
        load_abort   = 0;
        stream_valid = 0;
    endtask

    task automatic compare_writes(input logic [1:0] bank, input logic [7:0] base,
                                  input int n, input logic [23:0] cols [$]);
        chk("n_writes", obs_q.size(), n);
        for (int k = 0; k < n && k < obs_q.size(); k++) begin
            int a;
            a = int'(bank) * 1024 + ((int'(base) + k) % 256) * 4;
            chk("wr_addr", {20'h0, obs_q[k][43:32]}, a);
            chk("wr_data", obs_q[k][31:0], {8'h00, cols[k]});
        end
    endtask

    // cpu_mode: 0 none, 1 reads on loop cycles 2 and 3, 2 random reads/writes.
    task automatic run_load(input logic [1:0] bank, input logic [7:0] base, input int count,
                            input int abort_after, input int reset_after,
                            input int cpu_mode, input int vprob);
        logic [23:0] cols [$];
        int n, hsn, cyc, abort_cyc, budget;
        bit finished;
        obs_q.delete();
        done_cnt = 0;
        for (int k = 0; k < count; k++) cols.push_back(24'h112233 + 24'(k) * 24'h111111);
        n = (abort_after >= 0 && abort_after < count) ? abort_after : count;
        budget = count * 12 + 40;
        abort_cyc = -1;

        load_bank  = bank;
        load_base  = base;
        load_count = 9'(count);
        load_start = 1;
        load_abort = 1'($urandom_range(1));
        stream_valid = 1;
        stream_data  = 24'($urandom);
        @(negedge clock);
        observe();
        @(posedge clock); #1;

        hsn = 0; cyc = 0; finished = 0;
        while (!finished) begin
            cyc++;
            cpu_request = 0;
            cpu_write   = 0;
            if (cpu_mode == 1 && (cyc == 2 || cyc == 3)) begin
                cpu_request = 1;
                cpu_address = (cyc == 2) ? 12'h000 : 12'hFFC;
            end else if (cpu_mode == 2 && $urandom_range(3) == 0) begin
                cpu_request = 1;
                cpu_write   = ($urandom_range(9) < 3);
                cpu_address = 12'($urandom);
                cpu_wdata   = $urandom;
            end
            stream_valid = (hsn < count) && ($urandom_range(99) < vprob);
            stream_data  = stream_valid ? cols[hsn] : 24'($urandom);
            load_abort   = 0;
            if (abort_after >= 1 && hsn == abort_after - 1 && abort_cyc < 0) begin
                stream_valid = 1;
                stream_data  = cols[hsn];
                cpu_request  = 0;
                load_abort   = 1;
                abort_cyc    = cyc;
            end
            load_start = ($urandom_range(7) == 0);
            load_bank  = 2'($urandom);
            load_base  = 8'($urandom);
            load_count = 9'($urandom);
            @(negedge clock);
            observe();
            if (hs) hsn++;
            if (cyc == 1) chk("busy_after_start", {31'h0, load_busy}, {31'h0, count != 0});
            if (done_seen) begin
                finished = 1;
                chk("done_busy_low", {31'h0, load_busy}, 32'h0);
                chk("done_written", {23'h0, load_written}, n);
                chk("handshakes", hsn, n);
                if (abort_cyc >= 0) chk("abort_latency", cyc, abort_cyc + 1);
                else if (vprob == 100 && cpu_mode == 0) chk("done_latency", cyc, count + 1);
            end else if (reset_after >= 0 && hsn == reset_after) begin
                @(posedge clock); #1;
                idle_inputs();
                reset = 1;
                #1;
                chk("rst_busy", {31'h0, load_busy}, 32'h0);
                chk("rst_done", {31'h0, load_done}, 32'h0);
                chk("rst_written", {23'h0, load_written}, 32'h0);
                chk("rst_ready", {31'h0, stream_ready}, 32'h0);
                chk("rst_aux_req", {31'h0, aux_palette_request}, 32'h0);
                repeat (2) begin
                    @(negedge clock);
                    observe();
                end
                @(posedge clock); #1;
                reset = 0;
                @(negedge clock);
                observe();
                chk("no_done_on_reset", done_cnt, 0);
                compare_writes(bank, base, reset_after, cols);
                for (int k = 0; k < reset_after; k++)
                    chk("pal_kept", pal_env[int'(bank) * 256 + (int'(base) + k) % 256], {8'h00, cols[k]});
                @(posedge clock); #1;
                return;
            end else if (cyc > budget) begin
                chk("timeout_waiting_done", cyc, budget);
                finished = 1;
            end
            @(posedge clock); #1;
        end
        idle_inputs();
        @(negedge clock);
        observe();
        chk("done_one_cycle", {31'h0, load_done}, 32'h0);
        chk("idle_busy", {31'h0, load_busy}, 32'h0);
        chk("written_hold", {23'h0, load_written}, n);
        chk("done_pulses", done_cnt, 1);
        compare_writes(bank, base, n, cols);
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic        req;
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_req;
        logic        exp_ready;
        logic [31:0] exp_rdata_next;
    } vec_t;

    initial begin
        vec_t vecs [7];
        vecs[0] = '{1'b1, 12'h000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 12'hFFC, 1'b1, 32'h00C0FFEE, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 12'h000, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 12'h5A4, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 12'hFFF, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00C0FFEE};
        vecs[5] = '{1'b1, 12'h002, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 12'h000, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};

        reset = 0;
        idle_inputs();
        cpu_address = 12'h0;
        cpu_wdata   = 32'h0;
        load_bank   = 0;
        load_base   = 0;
        load_count  = 0;
        stream_data = 0;
        #2;
        reset = 1;
        cpu_request = 1;
        cpu_address = 12'h3A8;
        stream_valid = 1;
        #1;
        chk("reset_busy", {31'h0, load_busy}, 32'h0);
        chk("reset_done", {31'h0, load_done}, 32'h0);
        chk("reset_written", {23'h0, load_written}, 32'h0);
        chk("reset_ready", {31'h0, stream_ready}, 32'h0);
        chk("reset_passthru_req", {31'h0, aux_palette_request}, 32'h1);
        chk("reset_passthru_addr", {20'h0, aux_palette_address}, 32'h3A8);
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++) begin
            cpu_request  = vecs[i].req;
            cpu_address  = vecs[i].addr;
            cpu_write    = vecs[i].wr;
            cpu_wdata    = vecs[i].wdata;
            stream_valid = 1;
            load_abort   = 1'($urandom_range(1));
            @(negedge clock);
            chk("vec_req", {31'h0, aux_palette_request}, {31'h0, vecs[i].exp_req});
            chk("vec_addr", {20'h0, aux_palette_address}, {20'h0, vecs[i].addr});
            chk("vec_wr", {31'h0, aux_palette_write}, {31'h0, vecs[i].wr});
            chk("vec_wdata", aux_palette_wdata, vecs[i].wdata);
            chk("vec_ready", {31'h0, stream_ready}, {31'h0, vecs[i].exp_ready});
            chk("vec_busy", {31'h0, load_busy}, 32'h0);
            if (i > 0) chk("vec_rdata", cpu_rdata, vecs[i-1].exp_rdata_next);
            @(posedge clock); #1;
        end
        idle_inputs();
        @(negedge clock);
        chk("vec_rdata_last", cpu_rdata, vecs[6].exp_rdata_next);
        @(posedge clock); #1;
        rd_pend = 0;

        run_load(2'd2, 8'h10, 4, -1, -1, 0, 100);
        run_load(2'd1, 8'hFE, 4, -1, -1, 0, 100);
        run_load(2'd0, 8'h30, 8, -1, -1, 1, 100);
        run_load(2'd3, 8'h00, 0, -1, -1, 0, 100);
        run_load(2'd1, 8'h40, 100, 5, -1, 0, 100);
        run_load(2'd3, 8'h20, 10, -1, 3, 0, 100);
        run_load(2'd3, 8'h80, 6, -1, -1, 0, 100);
        run_load(2'd2, 8'h00, 256, -1, -1, 0, 100);

        for (int r = 0; r < 10; r++) begin
            int cnt, ab;
            cnt = (r == 0) ? 256 : $urandom_range(0, 60);
            ab  = (cnt >= 1 && $urandom_range(3) == 0) ? $urandom_range(1, cnt) : -1;
            run_load(2'($urandom), 8'($urandom), cnt, ab, -1, 2, $urandom_range(50, 100));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
